// File: rtl/shift_unit_pkg.sv
// Shared encodings for the multi-cycle shifter: shift modes, FSM states
// and the RUN-cycle count helper.
package shift_unit_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of RUN cycles needed to walk all shamt bits, spc stages at a time.
  function automatic int num_groups(input int shamt_w, input int spc);
    return (shamt_w + spc - 1) / spc;
  endfunction

endpackage

// File: rtl/shift_unit_if.sv
// ALU <-> shifter handshake bundle with master (ALU) and slave (shifter) views.
interface shift_unit_if
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  // Handshake: an operation is accepted on a rising edge where start=1 and
  // ready=1; start while ready=0 is dropped. done pulses for one cycle when
  // result becomes valid, and result holds until the next accepted start.
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  state_e             state;

  modport master (
    output start, mode, operand, shamt,
    input  ready, busy, done, result, state
  );

  modport slave (
    input  start, mode, operand, shamt,
    output ready, busy, done, result, state
  );

endinterface

// File: rtl/shift_unit_stage.sv
// One barrel stage: shifts by 2^k in the selected mode when enabled,
// otherwise passes data straight through.
module shift_stage
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic             fill,
  input  logic             en,
  input  logic [IDX_W-1:0] k,
  output logic [WIDTH-1:0] data_out
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] ONE_V   = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W+1)'(WIDTH);

  logic [SHAMT_W:0]   amt;
  logic [WIDTH-1:0]   fill_mask;

  always_comb begin
    amt       = ONE_V << k;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    data_out  = data_in;
    if (en) begin
      case (mode)
        MODE_SLL: data_out = data_in << amt;
        MODE_SRL: data_out = data_in >> amt;
        MODE_SRA: data_out = (data_in >> amt) | (fill ? fill_mask : '0);
        MODE_ROR: data_out = (data_in >> amt) | (data_in << (WIDTH_V - amt));
        default:  data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: latches an operation on start, applies
// STAGES_PER_CYCLE barrel stages per RUN cycle, then pulses done.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int STAGES_PER_CYCLE = 1
) (
  input logic         clock,
  input logic         reset,
  shift_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int L       = num_groups(SHAMT_W, STAGES_PER_CYCLE);
  localparam int CNT_W   = SHAMT_W;
  localparam int IDX_W   = $clog2(2 * SHAMT_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   result_q;
  logic [1:0]         mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               fill_q;
  logic               done_q;
  logic               last;
  logic               ready_c;

  logic [STAGES_PER_CYCLE:0][WIDTH-1:0] chain;

  assign chain[0] = work_q;

  // Stage index is cnt*SPC+i; indices past the top shamt bit pass through.
  for (genvar i = 0; i < STAGES_PER_CYCLE; i++) begin : g_stage
    logic [IDX_W-1:0] idx;
    logic             en;
    assign idx = IDX_W'(int'(cnt_q) * STAGES_PER_CYCLE + i);
    assign en  = (idx < IDX_W'(SHAMT_W)) && (|(shamt_q & (SHAMT_W'(1) << idx)));

    shift_stage #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_stage (
      .data_in  (chain[i]),
      .mode     (mode_q),
      .fill     (fill_q),
      .en       (en),
      .k        (idx),
      .data_out (chain[i+1])
    );
  end

  assign last = (cnt_q == CNT_W'(L - 1));

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      mode_q   <= MODE_SLL;
      shamt_q  <= '0;
      fill_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q  <= bus.operand;
            mode_q  <= bus.mode;
            shamt_q <= bus.shamt;
            fill_q  <= bus.operand[WIDTH-1];
            cnt_q   <= '0;
          end
        end
        RUN: begin
          work_q <= chain[STAGES_PER_CYCLE];
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            result_q <= chain[STAGES_PER_CYCLE];
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = ready_c;
  assign bus.busy   = ~ready_c;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: three builds (W32/SPC1, W32/SPC5, W8/SPC2)
// sharing clock and reset, checked against hand-computed results.
module tb_shift_unit;
  import shift_unit_pkg::*;

  logic clock;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  shift_unit_if #(.WIDTH(32)) bus32 ();
  shift_unit_if #(.WIDTH(32)) bus5 ();
  shift_unit_if #(.WIDTH(8))  bus8 ();

  shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(1)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32));
  shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(5)) u_dut5  (.clock(clock), .reset(reset), .bus(bus5));
  shift_unit #(.WIDTH(8),  .STAGES_PER_CYCLE(2)) u_dut8  (.clock(clock), .reset(reset), .bus(bus8));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks; sel 0 = W32/SPC1, 1 = W32/SPC5, 2 = W8/SPC2
  task automatic drive(input int sel, input logic s, input logic [1:0] m,
                       input logic [31:0] op, input logic [4:0] sh);
    case (sel)
      0: begin bus32.start = s; bus32.mode = m; bus32.operand = op; bus32.shamt = sh; end
      1: begin bus5.start = s; bus5.mode = m; bus5.operand = op; bus5.shamt = sh; end
      default: begin bus8.start = s; bus8.mode = m; bus8.operand = op[7:0]; bus8.shamt = sh[2:0]; end
    endcase
  endtask

  function automatic logic dut_done(input int sel);
    case (sel)
      0:       return bus32.done;
      1:       return bus5.done;
      default: return bus8.done;
    endcase
  endfunction

  function automatic logic [31:0] dut_result(input int sel);
    case (sel)
      0:       return bus32.result;
      1:       return bus5.result;
      default: return {24'h0, bus8.result};
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an op for one edge, then scrambles the inputs.
  task automatic launch(input int sel, input logic [1:0] m, input logic [31:0] op, input logic [4:0] sh);
    drive(sel, 1'b1, m, op, sh);
    tick();
    drive(sel, 1'b0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
  endtask

  task automatic wait_done(input int sel, input int lat0, output int lat);
    lat = lat0;
    while (!dut_done(sel) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input int sel, input logic [1:0] m, input logic [31:0] op,
                     input logic [4:0] sh, input logic [31:0] exp, input int exp_lat);
    int lat;
    launch(sel, m, op, sh);
    exp_q.push_back(exp);
    wait_done(sel, 1, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, dut_result(sel), exp_q.pop_front());
    tick();
    check({tag, "_pulse"}, 64'(dut_done(sel)), 64'd0);
  endtask

  task automatic count_done(input int sel, input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (dut_done(sel)) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b1;
    drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
    drive(1, 1'b0, MODE_SLL, 32'h0, 5'd0);
    drive(2, 1'b0, MODE_SLL, 32'h0, 5'd0);
    repeat (3) tick();
    reset = 1'b0;

    check("rst_ready",  64'(bus32.ready),  64'd1);
    check("rst_busy",   64'(bus32.busy),   64'd0);
    check("rst_done",   64'(bus32.done),   64'd0);
    check("rst_result", 64'(bus32.result), 64'd0);
    check("rst_state",  64'(bus32.state),  64'(IDLE));

    // Busy flags during the first RUN cycle, then completion of the same op.
    launch(0, MODE_SRA, 32'h8000_0000, 5'd16);
    check("run_ready", 64'(bus32.ready), 64'd0);
    check("run_busy",  64'(bus32.busy),  64'd1);
    wait_done(0, 1, lat);
    check("sra16_lat", 64'(lat), 64'd6);
    check("sra16",     64'(bus32.result), 64'hFFFF_8000);

    run("srl16",   0, MODE_SRL, 32'h8000_0000, 5'd16, 32'h0000_8000, 6);
    run("sll31",   0, MODE_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 6);
    run("ror4",    0, MODE_ROR, 32'h1234_5678, 5'd4,  32'h8123_4567, 6);
    run("sll8",    0, MODE_SLL, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00, 6);
    run("ror31",   0, MODE_ROR, 32'h8000_0001, 5'd31, 32'h0000_0003, 6);
    run("sra31p",  0, MODE_SRA, 32'h7FFF_0000, 5'd31, 32'h0000_0000, 6);
    run("sra31n",  0, MODE_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6);
    run("sll0",    0, MODE_SLL, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 6);
    run("srl0",    0, MODE_SRL, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 6);
    run("sra0",    0, MODE_SRA, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 6);
    run("ror0",    0, MODE_ROR, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 6);

    // start pulsed while busy must be dropped, not queued.
    launch(0, MODE_SRL, 32'hF0F0_F0F0, 5'd4);
    tick();
    drive(0, 1'b1, MODE_SLL, 32'hFFFF_FFFF, 5'd1);
    tick();
    drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
    wait_done(0, 3, lat);
    check("midrun_lat", 64'(lat), 64'd6);
    check("midrun",     64'(bus32.result), 64'h0F0F_0F0F);
    count_done(0, 8, pulses);
    check("midrun_pulses", 64'(pulses), 64'd0);

    // Back-to-back: second start lands in the done cycle of the first.
    launch(0, MODE_SLL, 32'h0000_00FF, 5'd4);
    wait_done(0, 1, lat);
    check("b2b_a", 64'(bus32.result), 64'h0000_0FF0);
    launch(0, MODE_ROR, 32'h1234_5678, 5'd8);
    check("b2b_hold", 64'(bus32.result), 64'h0000_0FF0);
    wait_done(0, 1, lat);
    check("b2b_lat", 64'(lat), 64'd6);
    check("b2b_b",   64'(bus32.result), 64'h7812_3456);

    // Reset during the 3rd RUN cycle aborts the op with no done.
    launch(0, MODE_SLL, 32'h0000_0001, 5'd5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready",  64'(bus32.ready),  64'd1);
    check("abort_busy",   64'(bus32.busy),   64'd0);
    check("abort_done",   64'(bus32.done),   64'd0);
    check("abort_result", 64'(bus32.result), 64'd0);
    count_done(0, 8, pulses);
    check("abort_pulses", 64'(pulses), 64'd0);
    run("post_abort", 0, MODE_SRA, 32'hC000_0000, 5'd1, 32'hE000_0000, 6);

    // Five stages per cycle: one RUN cycle.
    run("spc5_sra4",  1, MODE_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000, 2);
    run("spc5_ror20", 1, MODE_ROR, 32'h1234_5678, 5'd20, 32'h4567_8123, 2);
    run("spc5_sll31", 1, MODE_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);

    // Width 8, two stages per cycle: last group has a pass-through stage.
    run("w8_sra3", 2, MODE_SRA, 32'h90, 5'd3, 32'hF2, 3);
    run("w8_ror1", 2, MODE_ROR, 32'h81, 5'd1, 32'hC0, 3);
    run("w8_sll7", 2, MODE_SLL, 32'h0F, 5'd7, 32'h80, 3);
    run("w8_srl5", 2, MODE_SRL, 32'hFF, 5'd5, 32'h07, 3);
    run("w8_sra6", 2, MODE_SRA, 32'h70, 5'd6, 32'h01, 3);
    run("w8_ror7", 2, MODE_ROR, 32'h81, 5'd7, 32'h03, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
